// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a little-endian byte stream
// (count, payload words, XOR checksum), writes the words and holds the core until verified.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] words_written
);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

  state_t      state_r;
  state_t      state_next_s;
  logic [1:0]  byte_idx_r;
  logic [31:0] count_r;
  logic [31:0] word_r;
  logic [7:0]  csum_r;
  logic [31:0] words_written_r;
  logic [31:0] addr_r;
  logic        accept_state_s;
  logic        byte_ready_s;
  logic        byte_fire_s;
  logic        last_byte_s;
  logic [31:0] count_full_s;
  logic [31:0] words_next_s;

  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

  // Handshake decode; the full count is only meaningful on the 4th header byte.
  always_comb begin
    accept_state_s = (state_r == ST_HDR) || (state_r == ST_DATA) || (state_r == ST_CHK);
    byte_ready_s   = accept_state_s && !reset;
    byte_fire_s    = byte_valid && byte_ready_s;
    last_byte_s    = (byte_idx_r == 2'd3);
    count_full_s   = {byte_data, count_r[23:0]};
    words_next_s   = words_written_r + 32'd1;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (byte_fire_s && last_byte_s) begin
          if (count_full_s == 32'd0) begin
            state_next_s = ST_CHK;
          end else if (count_full_s > MAX_WORDS_W) begin
            state_next_s = ST_ERR;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DATA: begin
        if (byte_fire_s && last_byte_s) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          state_next_s = (words_next_s < count_r) ? ST_DATA : ST_CHK;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_CHK: begin
        if (byte_fire_s) begin
          state_next_s = (byte_data == csum_r) ? ST_DONE : ST_ERR;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_DONE: state_next_s = ST_DONE;
      ST_ERR:  state_next_s = ST_ERR;
      default: state_next_s = ST_ERR;
    endcase
  end

  // Datapath: count/word assembly, checksum and write address tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx_r      <= 2'd0;
      count_r         <= 32'd0;
      word_r          <= 32'd0;
      csum_r          <= 8'd0;
      words_written_r <= 32'd0;
      addr_r          <= BASE_ADDR;
    end else begin
      case (state_r)
        ST_HDR: begin
          if (byte_fire_s) begin
            count_r[{byte_idx_r, 3'b000} +: 8] <= byte_data;
            byte_idx_r                         <= byte_idx_r + 2'd1;
          end
        end
        ST_DATA: begin
          if (byte_fire_s) begin
            word_r[{byte_idx_r, 3'b000} +: 8] <= byte_data;
            csum_r                            <= csum_update(csum_r, byte_data);
            byte_idx_r                        <= byte_idx_r + 2'd1;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            words_written_r <= words_next_s;
            addr_r          <= addr_r + 32'd4;
          end
        end
        default: begin
          byte_idx_r <= byte_idx_r;
        end
      endcase
    end
  end

  // Output decode from registered state; reset forces the idle/held values immediately.
  always_comb begin
    byte_ready    = byte_ready_s;
    mem_we        = 1'b0;
    mem_addr      = BASE_ADDR;
    mem_wdata     = 32'd0;
    cpu_hold      = 1'b1;
    done          = 1'b0;
    error         = 1'b0;
    words_written = 32'd0;
    if (!reset) begin
      mem_we        = (state_r == ST_WRITE);
      mem_addr      = addr_r;
      mem_wdata     = word_r;
      cpu_hold      = (state_r != ST_DONE);
      done          = (state_r == ST_DONE);
      error         = (state_r == ST_ERR);
      words_written = words_written_r;
    end else begin
      byte_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of whole-stream loads plus
// hand-written back-pressure and mid-load reset sequences.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [31:0] words_written;

  int checks = 0;
  int failures = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  typedef struct packed {
    logic [0:15][7:0] bytes;
    logic [31:0]      nbytes;
    logic [31:0]      exp_ww;
    logic             exp_done;
    logic             exp_err;
    logic [0:1][31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  imem_loader #(.BASE_ADDR(32'h0100_0000), .MAX_WORDS(1024)) dut (
    .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_written(words_written)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: record committed writes; byte_ready must be low during any write.
  always @(posedge clock) begin
    if (mem_we && mem_ready) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      check("ready_during_write", {31'd0, byte_ready}, 32'd0);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    byte_valid = 1'b0;
    @(negedge clock);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_mem_addr", mem_addr, BASE);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_words_written", words_written, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_byte_ready", {31'd0, byte_ready}, 32'd1);
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 50;
    @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (budget == 0) begin
      check("byte_accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clock);
    end
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic check_final(input string tag, input vec_t v);
    check({tag, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
    check({tag, "_error"}, {31'd0, error}, {31'd0, v.exp_err});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !v.exp_done});
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_words_written"}, words_written, v.exp_ww);
    check({tag, "_write_count"}, 32'(wa_q.size()), v.exp_ww);
    for (int i = 0; i < int'(v.exp_ww) && i < wa_q.size(); i++) begin
      check({tag, "_addr"}, wa_q[i], BASE + 32'(4 * i));
      check({tag, "_data"}, wd_q[i], v.exp_data[i]);
    end
  endtask

  task automatic run_case(input int k);
    vec_t v;
    v = vecs[k];
    mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < int'(v.nbytes); i++) send_byte(v.bytes[i]);
    @(negedge clock);
    check_final($sformatf("case%0d", k), v);
  endtask

  initial begin
    // nominal two-word load
    vecs[0] = '{bytes: {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h93, 8'h00, 8'ha0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00},
                nbytes: 32'd13, exp_ww: 32'd2, exp_done: 1'b1, exp_err: 1'b0,
                exp_data: {32'h0000_0013, 32'h00a0_0093}};
    // zero count
    vecs[1] = '{bytes: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                nbytes: 32'd5, exp_ww: 32'd0, exp_done: 1'b1, exp_err: 1'b0,
                exp_data: {32'h0, 32'h0}};
    // N = 1025, one over the limit
    vecs[2] = '{bytes: {8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                nbytes: 32'd4, exp_ww: 32'd0, exp_done: 1'b0, exp_err: 1'b1,
                exp_data: {32'h0, 32'h0}};
    // bad checksum
    vecs[3] = '{bytes: {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h93, 8'h00, 8'ha0, 8'h00, 8'h21, 8'h00, 8'h00, 8'h00},
                nbytes: 32'd13, exp_ww: 32'd2, exp_done: 1'b0, exp_err: 1'b1,
                exp_data: {32'h0000_0013, 32'h00a0_0093}};
    // count with nonzero upper byte (0x01000001)
    vecs[4] = '{bytes: {8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                nbytes: 32'd4, exp_ww: 32'd0, exp_done: 1'b0, exp_err: 1'b1,
                exp_data: {32'h0, 32'h0}};
    // single word, checksum ef^be^ad^de = 22
    vecs[5] = '{bytes: {8'h01, 8'h00, 8'h00, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde,
                        8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                nbytes: 32'd9, exp_ww: 32'd1, exp_done: 1'b1, exp_err: 1'b0,
                exp_data: {32'hdead_beef, 32'h0}};

    for (int k = 0; k < 6; k++) run_case(k);

    // back-pressure on the first write
    mem_ready = 1'b1;
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(vecs[0].bytes[i]);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("bp_mem_we", {31'd0, mem_we}, 32'd1);
      check("bp_mem_addr", mem_addr, 32'h0100_0000);
      check("bp_mem_wdata", mem_wdata, 32'h0000_0013);
      check("bp_byte_ready", {31'd0, byte_ready}, 32'd0);
      if (c == 3) mem_ready = 1'b1;
    end
    @(negedge clock);
    check("bp_after_ww", words_written, 32'd1);
    check("bp_after_ready", {31'd0, byte_ready}, 32'd1);
    check("bp_after_we", {31'd0, mem_we}, 32'd0);
    for (int i = 8; i < 13; i++) send_byte(vecs[0].bytes[i]);
    @(negedge clock);
    check_final("bp", vecs[0]);

    // DONE absorbs further bytes
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    @(negedge clock);
    check("done_absorb_done", {31'd0, done}, 32'd1);
    check("done_absorb_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;

    // reset after 6 bytes, then full nominal stream (run_case performs the reset)
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(vecs[0].bytes[i]);
    run_case(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
